// File: rtl/accel_bus_arbiter.sv
// Round-robin arbiter that time-shares the accelerometer SCLK/CS pins between the
// I2C and SPI masters, with a parked guard interval between owners and a hold watchdog.
module accel_bus_arbiter #(
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_50,
  input  logic reset,
  input  logic i2c_req,
  input  logic spi_req,
  input  logic i2c_scl_in,
  input  logic spi_sclk_in,
  input  logic spi_cs_n_in,
  input  logic timeout_clr,
  output logic i2c_gnt,
  output logic spi_gnt,
  output logic bus_sclk,
  output logic gsensor_cs_n,
  output logic busy,
  output logic timeout_flag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I2C = 2'd1,
    GNT_SPI = 2'd2,
    GUARD   = 2'd3
  } state_t;

  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [19:0] HOLD_LAST  = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic        last_owner_reg;  // 0 = I2C, 1 = SPI
  logic [7:0]  guard_cnt_reg;
  logic [19:0] hold_cnt_reg;
  logic        timeout_flag_reg;
  logic [1:0]  mask_reg;
  logic [1:0]  req;
  logic [1:0]  req_eff;
  logic [1:0]  owns;
  logic [1:0]  mask_set;
  logic        owner_req;
  logic        hold_expired;

  assign req          = {spi_req, i2c_req};
  assign owns         = {state_reg == GNT_SPI, state_reg == GNT_I2C};
  assign owner_req    = |(owns & req);
  assign hold_expired = (hold_cnt_reg == HOLD_LAST);

  // Index 0 is the I2C requester, index 1 the SPI requester.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_eff[gi]  = req[gi] & ~mask_reg[gi];
      assign mask_set[gi] = owns[gi] & req[gi] & hold_expired;

      // A timed-out owner stays locked out until it drops its request once.
      always_ff @(posedge clk_50) begin
        if (reset) begin
          mask_reg[gi] <= 1'b0;
        end else if (!req[gi]) begin
          mask_reg[gi] <= 1'b0;
        end else if (mask_set[gi]) begin
          mask_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg        <= IDLE;
      last_owner_reg   <= 1'b1;
      guard_cnt_reg    <= 8'd0;
      hold_cnt_reg     <= 20'd0;
      timeout_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie the requester that did not own the bus last wins.
          if (req_eff[0] && (!req_eff[1] || last_owner_reg)) begin
            state_reg      <= GNT_I2C;
            last_owner_reg <= 1'b0;
            hold_cnt_reg   <= 20'd0;
          end else if (req_eff[1]) begin
            state_reg      <= GNT_SPI;
            last_owner_reg <= 1'b1;
            hold_cnt_reg   <= 20'd0;
          end
        end
        GNT_I2C, GNT_SPI: begin
          if (!owner_req || hold_expired) begin
            state_reg     <= GUARD;
            guard_cnt_reg <= 8'd0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 20'd1;
          end
        end
        GUARD: begin
          if (guard_cnt_reg == GUARD_LAST) begin
            state_reg <= IDLE;
          end else begin
            guard_cnt_reg <= guard_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (|mask_set) begin
        timeout_flag_reg <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag_reg <= 1'b0;
      end
    end
  end

  assign i2c_gnt      = owns[0];
  assign spi_gnt      = owns[1];
  assign busy         = (state_reg != IDLE);
  assign timeout_flag = timeout_flag_reg;

  // Pins idle high; CS stays high under I2C so the sensor remains in I2C mode.
  always_comb begin
    bus_sclk     = 1'b1;
    gsensor_cs_n = 1'b1;
    case (state_reg)
      GNT_I2C: bus_sclk = i2c_scl_in;
      GNT_SPI: begin
        bus_sclk     = spi_sclk_in;
        gsensor_cs_n = spi_cs_n_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_accel_bus_arbiter.sv
// Bench for accel_bus_arbiter: vector table, directed corner sequences and random
// traffic, all checked against a timestamp-based reference model.
module tb_accel_bus_arbiter;

  localparam int G = 8;
  localparam int T = 20;

  logic clk_50 = 1'b0;
  logic reset = 1'b1;
  logic i2c_req = 1'b0, spi_req = 1'b0;
  logic i2c_scl_in = 1'b0, spi_sclk_in = 1'b0, spi_cs_n_in = 1'b1;
  logic timeout_clr = 1'b0;
  logic i2c_gnt, spi_gnt, bus_sclk, gsensor_cs_n, busy, timeout_flag;

  accel_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk_50(clk_50), .reset(reset), .i2c_req(i2c_req), .spi_req(spi_req),
    .i2c_scl_in(i2c_scl_in), .spi_sclk_in(spi_sclk_in), .spi_cs_n_in(spi_cs_n_in),
    .timeout_clr(timeout_clr), .i2c_gnt(i2c_gnt), .spi_gnt(spi_gnt),
    .bus_sclk(bus_sclk), .gsensor_cs_n(gsensor_cs_n), .busy(busy),
    .timeout_flag(timeout_flag)
  );

  always #5 clk_50 = ~clk_50;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner plus timestamps (edge of grant, earliest edge a new grant may occur).
  int edge_n = 0;
  int m_owner = 0;        // 0 none, 1 I2C, 2 SPI
  int m_grant_edge = 0;
  int m_earliest = 0;
  bit m_last_spi = 1'b1;
  bit m_mask [2];
  bit m_flag = 1'b0;

  task automatic model_edge();
    bit r [2];
    bit eff [2];
    bit timed_out;
    int pick;
    edge_n++;
    if (reset) begin
      m_owner = 0; m_last_spi = 1'b1; m_mask[0] = 0; m_mask[1] = 0;
      m_flag = 0; m_earliest = edge_n + 1;
      return;
    end
    r[0] = i2c_req; r[1] = spi_req;
    eff[0] = r[0] && !m_mask[0]; eff[1] = r[1] && !m_mask[1];
    timed_out = 0;
    if (m_owner != 0) begin
      pick = m_owner - 1;
      if (!r[pick]) begin
        m_owner = 0; m_earliest = edge_n + G + 1;
      end else if (edge_n - m_grant_edge == T) begin
        m_mask[pick] = 1; timed_out = 1; m_owner = 0; m_earliest = edge_n + G + 1;
      end
    end else if (edge_n >= m_earliest && (eff[0] || eff[1])) begin
      pick = (eff[0] && eff[1]) ? (m_last_spi ? 0 : 1) : (eff[0] ? 0 : 1);
      m_owner = pick + 1; m_last_spi = (pick == 1); m_grant_edge = edge_n;
    end
    for (int i = 0; i < 2; i++) if (!r[i]) m_mask[i] = 0;
    if (timeout_clr) m_flag = 0;
    if (timed_out) m_flag = 1;
  endtask

  function automatic logic [5:0] model_out();
    logic sclk, cs;
    sclk = (m_owner == 1) ? i2c_scl_in : (m_owner == 2) ? spi_sclk_in : 1'b1;
    cs   = (m_owner == 2) ? spi_cs_n_in : 1'b1;
    return {m_owner == 1, m_owner == 2, sclk, cs,
            (m_owner != 0) || (edge_n < m_earliest - 1), m_flag};
  endfunction

  function automatic logic [5:0] dut_out();
    return {i2c_gnt, spi_gnt, bus_sclk, gsensor_cs_n, busy, timeout_flag};
  endfunction

  task automatic tick();
    @(posedge clk_50);
    model_edge();
    #1;
    check("model", 32'(dut_out()), 32'(model_model_wrap()));
  endtask

  function automatic logic [5:0] model_model_wrap();
    return model_out();
  endfunction

  typedef struct {
    logic rst, ireq, sreq, scl, sclk, csn;
    logic [5:0] exp;  // {i2c_gnt, spi_gnt, bus_sclk, gsensor_cs_n, busy, timeout_flag}
  } vec_t;

  vec_t vecs [18];
  int fall_cyc, n, last_fall;
  logic seen, prev_any;

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 1, 6'b001100};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 6'b001100};
    vecs[2]  = '{0, 1, 0, 0, 0, 1, 6'b100110};
    vecs[3]  = '{0, 1, 0, 1, 0, 1, 6'b101110};
    vecs[4]  = '{0, 1, 1, 0, 0, 0, 6'b100110};
    for (int i = 5; i <= 12; i++) vecs[i] = '{0, 0, 1, 0, 0, 0, 6'b001110};
    vecs[13] = '{0, 0, 1, 0, 0, 0, 6'b001100};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 6'b010010};
    vecs[15] = '{0, 0, 1, 0, 1, 0, 6'b011010};
    vecs[16] = '{0, 1, 1, 0, 0, 0, 6'b010010};
    vecs[17] = '{0, 0, 1, 0, 1, 1, 6'b011110};

    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst; i2c_req = vecs[i].ireq; spi_req = vecs[i].sreq;
      i2c_scl_in = vecs[i].scl; spi_sclk_in = vecs[i].sclk; spi_cs_n_in = vecs[i].csn;
      tick();
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end

    // Round-robin: SPI releases, both re-request, I2C must win after G+1 cycles.
    spi_req = 0; tick(); fall_cyc = edge_n;
    i2c_req = 1; spi_req = 1; n = 0;
    while (!(i2c_gnt || spi_gnt) && n < 30) begin tick(); n++; end
    check("rr_i2c_wins", {i2c_gnt, spi_gnt}, 2'b10);
    check("rr_gap", edge_n - fall_cyc, G + 1);

    // Hold timeout on SPI.
    i2c_req = 0; spi_req = 0; reset = 1; tick(); reset = 0;
    spi_req = 1; tick();
    check("to_grant", spi_gnt, 1);
    n = 0;
    while (spi_gnt && n < 100) begin n++; tick(); end
    check("to_hold_len", n, T);
    check("to_flag_set", timeout_flag, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); seen |= spi_gnt; end
    check("to_no_regrant", seen, 0);
    spi_req = 0; tick(); spi_req = 1; n = 0;
    while (!spi_gnt && n < 20) begin tick(); n++; end
    check("to_regrant", spi_gnt, 1);
    check("to_flag_sticky", timeout_flag, 1);
    spi_req = 0; timeout_clr = 1; tick(); timeout_clr = 0;
    check("to_flag_clr", timeout_flag, 0);

    // Reset while I2C owns the bus.
    i2c_req = 1; i2c_scl_in = 0; n = 0;
    while (!i2c_gnt && n < 30) begin tick(); n++; end
    check("rst_pre_grant", i2c_gnt, 1);
    reset = 1; tick();
    check("rst_drop", {i2c_gnt, busy, bus_sclk}, 3'b001);
    reset = 0; tick();
    check("rst_regrant", i2c_gnt, 1);

    // Random traffic.
    last_fall = -1000; prev_any = 1;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 15) == 0) i2c_req = ~i2c_req;
      if ($urandom_range(0, 15) == 0) spi_req = ~spi_req;
      timeout_clr = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 2999) == 0);
      i2c_scl_in = 1'($urandom); spi_sclk_in = 1'($urandom); spi_cs_n_in = 1'($urandom);
      tick();
      check("mutex", i2c_gnt & spi_gnt, 0);
      if (reset) last_fall = -1000;
      else if (prev_any && !(i2c_gnt || spi_gnt)) last_fall = edge_n;
      else if (!prev_any && (i2c_gnt || spi_gnt) && last_fall > 0)
        check("gap_min", (edge_n - last_fall) >= G + 1, 1);
      prev_any = i2c_gnt || spi_gnt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
